wb_pipe_mem_tester: RTL
=======================

Name: wb_pipe_mem_tester

Overview:
- Wishbone pipelined bus master that writes a deterministic pattern over a DRAM word range, then reads it back and checks every word.
- Drives one 32-bit pipelined user port of the DRAM controller wrapper, directly or through the interconnect.
- Used for memory bring-up and for regression of the pipelined-to-classic port adaptation.
- Keeps up to MAX_OUTSTANDING requests in flight, honours stall, and reports a pass/fail summary.

Parameters:
- MAX_OUTSTANDING, 4, maximum issued-but-unacknowledged requests (1..15).
- CNT_W, 24, width of the word-count input and the internal index counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that starts a test run. Ignored while busy.
- base_adr  in  32  byte address of the first word. Bits [1:0] are ignored and treated as 0.
- num_words  in  CNT_W  number of 32-bit words to test.
- seed  in  32  pattern seed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  result of the last run. Valid from done until the next start.
- err_count  out  16  number of miscompares plus bus errors, saturating at 0xFFFF.
- first_err_adr  out  32  byte address of the first failing word. 0 if the run passed.
- wb_adr  out  32  byte address.
- wb_dat_w  out  32  write data.
- wb_dat_r  in  32  read data.
- wb_sel  out  4  byte enables, always 4'hF.
- wb_stall  in  1  slave stall.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_ack  in  1  acknowledge.
- wb_we  out  1  write enable.
- wb_err  in  1  bus error.

Behaviour:
- Reset values: all outputs 0, except wb_sel = 4'hF. Reset asserted mid-run drops cyc, stb and busy immediately. Counters clear, and no done pulse is produced.
- Pattern: word i is at byte address A(i) = base_adr + 4*i. Its data is P(i) = seed ^ A(i). Addresses wrap modulo 2^32.
- State machine:
  - IDLE -> WR on start with num_words != 0.
  - IDLE -> FIN on start with num_words == 0.
  - WR -> WR_DRAIN after the last write is accepted.
  - WR_DRAIN -> GAP when the outstanding count reaches 0.
  - GAP -> RD after exactly 1 cycle, during which cyc is low.
  - RD -> RD_DRAIN after the last read is accepted.
  - RD_DRAIN -> FIN when the outstanding count reaches 0.
  - FIN -> IDLE after 1 cycle, during which done is pulsed.
- Inputs base_adr, num_words and seed are latched on the accepted start. Later changes have no effect on the running test.
- busy is high in every state except IDLE.
- wb_cyc is high in WR, WR_DRAIN, RD and RD_DRAIN only.
- Issue rule:
  - wb_stb is high in WR/RD when the issue index < num_words and outstanding < MAX_OUTSTANDING.
  - A request is accepted on stb && !stall. The issue index advances only on acceptance.
  - adr, dat_w and we are held stable while stb && stall.
  - Back-to-back issue at 1 request/cycle is possible when the slave does not stall.
- Outstanding counter:
  - Increments on acceptance and decrements on ack or err.
  - Simultaneous accept and response leaves the count unchanged.
  - A response with outstanding == 0 is ignored and not counted.
- Read check:
  - Responses arrive in order. A check index advances on each RD/RD_DRAIN response.
  - Miscompare occurs when ack and dat_r != P(check index).
  - wb_err in any phase counts as one error. A write err uses the write response index for first_err_adr.
  - first_err_adr captures A(idx) for the first error only.
- In FIN, pass = (err_count == 0).
- start during FIN or any busy state is ignored.
- With MAX_OUTSTANDING = 1, the master issues the next request only after the previous response.

Test Plan:
- Zero-wait slave model, base_adr=0x0000_1000, num_words=16, seed=0xA5A5_0000: 16 writes on consecutive cycles; first write data 0xA5A5_1000; done after both phases; pass=1, err_count=0, first_err_adr=0.
- Slave stalls every 2nd cycle and delays ack by 3 cycles, num_words=32: outstanding never exceeds 4; adr/dat_w stable under stall; pass=1.
- Slave corrupts the read of word 5 (XOR 0x1), base 0x0: pass=0, err_count=1, first_err_adr=0x0000_0014.
- wb_err on write 2 and on read 7, base 0x100: err_count=2, first_err_adr=0x0000_0108.
- num_words=0: done 2 cycles after start, no cyc activity, pass=1. start pulse while busy: no restart, count unchanged.
- Reset asserted in RD with 3 requests outstanding: cyc/stb/busy are 0 in the same cycle. A following start runs cleanly and ends with pass=1.

Source files
------------

// File: rtl/wb_pipe_mem_tester.sv
// wb_pipe_mem_tester: pipelined Wishbone master that writes seed^address over a word range and reads it back for checking
module wb_pipe_mem_tester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] num_words,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [31:0]      first_err_adr,
  output logic [31:0]      wb_adr,
  output logic [31:0]      wb_dat_w,
  input  logic [31:0]      wb_dat_r,
  output logic [3:0]       wb_sel,
  input  logic             wb_stall,
  output logic             wb_cyc,
  output logic             wb_stb,
  input  logic             wb_ack,
  output logic             wb_we,
  input  logic             wb_err
);
  typedef enum logic [2:0] {IDLE, WR, WR_DRAIN, GAP, RD, RD_DRAIN, FIN} st_t;
  st_t st, nxt;
  logic [31:0] base, sd, chk_adr;
  logic [CNT_W-1:0] n, iss, chk;
  logic [3:0] out;
  logic acc, rsp, last, rd_ph, bad;
  assign wb_adr = base + (32'(iss) << 2);
  assign wb_dat_w = sd ^ wb_adr;
  assign wb_sel = 4'hF;
  assign wb_we = st == WR;
  assign wb_cyc = st == WR || st == WR_DRAIN || st == RD || st == RD_DRAIN;
  assign wb_stb = (st == WR || st == RD) && iss < n && out < 4'(MAX_OUTSTANDING);
  assign busy = st != IDLE;
  assign done = st == FIN;
  assign acc = wb_stb && !wb_stall;
  assign rsp = (wb_ack || wb_err) && out != 4'd0;
  assign last = iss == n - 1'b1;
  assign rd_ph = st == RD || st == RD_DRAIN;
  assign chk_adr = base + (32'(chk) << 2);
  // chk tracks the response index in both phases, so write errors report their own word
  assign bad = rsp && (wb_err || (rd_ph && wb_dat_r != (sd ^ chk_adr)));
  always_comb begin
    nxt = st;
    case (st)
      IDLE:     if (start) nxt = num_words == '0 ? FIN : WR;
      WR:       if (acc && last) nxt = WR_DRAIN;
      WR_DRAIN: if (out == 4'd0) nxt = GAP;
      GAP:      nxt = RD;
      RD:       if (acc && last) nxt = RD_DRAIN;
      RD_DRAIN: if (out == 4'd0) nxt = FIN;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      base <= '0;
      sd <= '0;
      n <= '0;
      iss <= '0;
      chk <= '0;
      out <= '0;
      err_count <= '0;
      first_err_adr <= '0;
      pass <= 1'b0;
    end else begin
      st <= nxt;
      out <= out + 4'(acc) - 4'(rsp);
      if (st == IDLE && start) begin
        base <= base_adr & ~32'h3;
        sd <= seed;
        n <= num_words;
        iss <= '0;
        chk <= '0;
        err_count <= '0;
        first_err_adr <= '0;
        pass <= 1'b0;
      end else if (st == GAP) begin
        iss <= '0;
        chk <= '0;
      end else begin
        if (acc) iss <= iss + 1'b1;
        if (rsp) chk <= chk + 1'b1;
        if (bad && err_count == 16'd0) first_err_adr <= chk_adr;
        if (bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (nxt == FIN) pass <= st == IDLE || err_count == 16'd0;
    end
  end
endmodule
